// File: rtl/int_ctrl.sv
// Machine-level interrupt controller: mie/mip registers, int_ext synchronizer,
// fixed-priority selection and a request/acknowledge/return handshake with the core.
module int_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        int_timer,
    input  logic        int_soft,
    input  logic        int_ext,
    input  logic        sel,
    input  logic [15:0] addr,
    input  logic [2:0]  we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        global_ie,
    output logic        irq_req,
    output logic [3:0]  irq_cause,
    input  logic        irq_ack,
    input  logic        mret
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    localparam logic [31:0] MIE_MASK = 32'h0000_0888;
    localparam logic [15:0] ADDR_MIE = 16'h0000;
    localparam logic [15:0] ADDR_MIP = 16'h0004;

    logic [31:0]            mie_q, mie_d;
    logic [SYNC_STAGES-1:0] ext_sync_q;
    logic                   timer_q, soft_q;
    logic [31:0]            mip, pending;
    logic                   eligible;
    logic [3:0]             cause_d;
    state_t                 state_q;
    logic                   irq_req_q;
    logic [3:0]             irq_cause_q;

    always_comb begin
        mie_d = mie_q;
        if (sel && we[2] && (we[1:0] == 2'b10) && (addr == ADDR_MIE))
            mie_d = wdata & MIE_MASK;
    end

    always_comb begin
        mip     = '0;
        mip[11] = ext_sync_q[SYNC_STAGES-1];
        mip[7]  = timer_q;
        mip[3]  = soft_q;
    end

    assign pending  = mip & mie_q;
    assign eligible = (|pending) && global_ie;

    // External outranks software, which outranks timer.
    always_comb begin
        if (pending[11])     cause_d = 4'd11;
        else if (pending[3]) cause_d = 4'd3;
        else                 cause_d = 4'd7;
    end

    always_comb begin
        rdata = 32'h0;
        if (sel) begin
            if (addr == ADDR_MIE)      rdata = mie_q;
            else if (addr == ADDR_MIP) rdata = mip;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= '0;
            ext_sync_q <= '0;
            timer_q    <= 1'b0;
            soft_q     <= 1'b0;
        end else begin
            mie_q      <= mie_d;
            ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], int_ext};
            timer_q    <= int_timer;
            soft_q     <= int_soft;
        end
    end

    // Cause is captured once on entry to REQ and held until the core acknowledges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            irq_req_q   <= 1'b0;
            irq_cause_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: if (eligible) begin
                    state_q     <= REQ;
                    irq_req_q   <= 1'b1;
                    irq_cause_q <= cause_d;
                end
                REQ: if (irq_ack) begin
                    state_q   <= SERVICE;
                    irq_req_q <= 1'b0;
                end
                SERVICE: if (mret) state_q <= IDLE;
                default: begin
                    state_q   <= IDLE;
                    irq_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req   = irq_req_q;
    assign irq_cause = irq_cause_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: register-access vector table plus hand-written
// request/ack/mret, priority, gating and asynchronous-reset sequences.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        int_timer, int_soft, int_ext;
    logic        sel;
    logic [15:0] addr;
    logic [2:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        global_ie;
    logic        irq_req;
    logic [3:0]  irq_cause;
    logic        irq_ack;
    logic        mret;

    int n_cmp = 0;
    int n_err = 0;

    int_ctrl #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .int_timer(int_timer), .int_soft(int_soft), .int_ext(int_ext),
        .sel(sel), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata),
        .global_ie(global_ie), .irq_req(irq_req), .irq_cause(irq_cause),
        .irq_ack(irq_ack), .mret(mret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wsel;
        logic [15:0] waddr;
        logic [2:0]  wwe;
        logic [31:0] wdat;
        logic        rsel;
        logic [15:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic s, input logic [15:0] a);
        we = 3'b000; sel = s; addr = a;
        #1;
    endtask

    initial begin
        vecs[0]  = '{"rd_mie_rst",   1'b0, 16'h0000, 3'b000, 32'h0,        1'b1, 16'h0000, 32'h0};
        vecs[1]  = '{"rd_mip_rst",   1'b0, 16'h0000, 3'b000, 32'h0,        1'b1, 16'h0004, 32'h0};
        vecs[2]  = '{"rd_nosel",     1'b0, 16'h0000, 3'b000, 32'h0,        1'b0, 16'h0000, 32'h0};
        vecs[3]  = '{"wr_mie_all",   1'b1, 16'h0000, 3'b110, 32'hFFFFFFFF, 1'b1, 16'h0000, 32'h00000888};
        vecs[4]  = '{"rd_mie_nosel", 1'b0, 16'h0000, 3'b000, 32'h0,        1'b0, 16'h0000, 32'h0};
        vecs[5]  = '{"wr_mip_ro",    1'b1, 16'h0004, 3'b110, 32'hFFFFFFFF, 1'b1, 16'h0004, 32'h0};
        vecs[6]  = '{"rd_unmapped",  1'b0, 16'h0000, 3'b000, 32'h0,        1'b1, 16'h0008, 32'h0};
        vecs[7]  = '{"wr_byte_ign",  1'b1, 16'h0000, 3'b100, 32'h0,        1'b1, 16'h0000, 32'h00000888};
        vecs[8]  = '{"wr_nosel_ign", 1'b0, 16'h0000, 3'b110, 32'h0,        1'b1, 16'h0000, 32'h00000888};
        vecs[9]  = '{"wr_nostb_ign", 1'b1, 16'h0000, 3'b010, 32'h0,        1'b1, 16'h0000, 32'h00000888};
        vecs[10] = '{"wr_addr_ign",  1'b1, 16'h0100, 3'b110, 32'h0,        1'b1, 16'h0000, 32'h00000888};
        vecs[11] = '{"wr_mie_soft",  1'b1, 16'h0000, 3'b110, 32'h00000008, 1'b1, 16'h0000, 32'h00000008};
        vecs[12] = '{"wr_mie_back",  1'b1, 16'h0000, 3'b110, 32'hFFFFFFFF, 1'b1, 16'h0000, 32'h00000888};

        rst_n = 1'b0; int_timer = 0; int_soft = 0; int_ext = 0;
        sel = 1'b1; addr = 16'h0; we = 3'b000; wdata = 32'h0;
        global_ie = 0; irq_ack = 0; mret = 0;
        #1;
        check("rst_irq_req", {31'b0, irq_req}, 32'h0);
        check("rst_irq_cause", {28'b0, irq_cause}, 32'h0);
        check("rst_rdata_mie", rdata, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Register access table
        foreach (vecs[i]) begin
            sel = vecs[i].wsel; addr = vecs[i].waddr; we = vecs[i].wwe; wdata = vecs[i].wdat;
            tick();
            rd(vecs[i].rsel, vecs[i].raddr);
            check(vecs[i].name, rdata, vecs[i].exp);
            check({vecs[i].name, "_noreq"}, {31'b0, irq_req}, 32'h0);
        end

        // Timer request, held through source/global_ie drop, mret ignored in REQ
        @(negedge clk);
        global_ie = 1; int_timer = 1;
        tick();
        check("tmr_edge1_noreq", {31'b0, irq_req}, 32'h0);
        tick();
        check("tmr_edge2_req", {31'b0, irq_req}, 32'h1);
        check("tmr_cause", {28'b0, irq_cause}, 32'd7);
        rd(1'b1, 16'h0004);
        check("tmr_mip", rdata, 32'h00000080);
        @(negedge clk);
        int_timer = 0; global_ie = 0;
        tick(); tick(); tick();
        check("tmr_held_req", {31'b0, irq_req}, 32'h1);
        check("tmr_held_cause", {28'b0, irq_cause}, 32'd7);
        mret = 1; tick(); mret = 0;
        check("mret_in_req_ign", {31'b0, irq_req}, 32'h1);
        irq_ack = 1; tick(); irq_ack = 0;
        check("tmr_ack_drop", {31'b0, irq_req}, 32'h0);
        mret = 1; tick(); mret = 0;
        global_ie = 1;
        tick(); tick();
        check("tmr_idle_quiet", {31'b0, irq_req}, 32'h0);

        // Priority: all three sources, gated until synchronized
        global_ie = 0; int_timer = 1; int_soft = 1; int_ext = 1;
        tick(); tick(); tick();
        rd(1'b1, 16'h0004);
        check("all_mip", rdata, 32'h00000888);
        check("all_gated_noreq", {31'b0, irq_req}, 32'h0);
        @(negedge clk);
        global_ie = 1;
        tick();
        check("ext_req", {31'b0, irq_req}, 32'h1);
        check("ext_cause", {28'b0, irq_cause}, 32'd11);
        irq_ack = 1; tick(); irq_ack = 0;
        int_ext = 0;
        tick(); tick(); tick();
        check("service_no_req", {31'b0, irq_req}, 32'h0);
        rd(1'b1, 16'h0004);
        check("ext_cleared_mip", rdata, 32'h00000088);
        @(negedge clk);
        mret = 1; tick(); mret = 0;
        check("idle_gap", {31'b0, irq_req}, 32'h0);
        tick();
        check("soft_rereq", {31'b0, irq_req}, 32'h1);
        check("soft_cause", {28'b0, irq_cause}, 32'd3);
        irq_ack = 1; tick(); irq_ack = 0;
        int_soft = 0;
        tick();
        mret = 1; tick(); mret = 0;
        tick();
        check("tmr_rereq", {31'b0, irq_req}, 32'h1);
        check("tmr_rereq_cause", {28'b0, irq_cause}, 32'd7);
        irq_ack = 1; tick(); irq_ack = 0;
        int_timer = 0;
        tick(); tick();
        mret = 1; tick(); mret = 0;
        tick(); tick();
        check("all_done_quiet", {31'b0, irq_req}, 32'h0);

        // global_ie gating
        global_ie = 0; int_timer = 1;
        tick(); tick(); tick();
        check("gie0_noreq", {31'b0, irq_req}, 32'h0);
        @(negedge clk);
        global_ie = 1;
        tick();
        check("gie1_req", {31'b0, irq_req}, 32'h1);
        irq_ack = 1; tick(); irq_ack = 0;
        check("gie_in_service", {31'b0, irq_req}, 32'h0);

        // Asynchronous reset during SERVICE
        #2;
        rst_n = 0; sel = 1; addr = 16'h0000;
        #1;
        check("async_rst_req", {31'b0, irq_req}, 32'h0);
        check("async_rst_cause", {28'b0, irq_cause}, 32'h0);
        check("async_rst_mie", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1;
        mret = 1; tick(); mret = 0;
        tick();
        check("post_rst_mret_ign", {31'b0, irq_req}, 32'h0);
        rd(1'b1, 16'h0004);
        check("post_rst_mip", rdata, 32'h00000080);

        // mie write on the evaluation edge takes effect one edge later
        @(negedge clk);
        sel = 1; addr = 16'h0000; we = 3'b110; wdata = 32'h00000080;
        tick();
        we = 3'b000;
        check("mie_wr_edge_noreq", {31'b0, irq_req}, 32'h0);
        tick();
        check("mie_wr_next_req", {31'b0, irq_req}, 32'h1);
        check("mie_wr_cause", {28'b0, irq_cause}, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the flop depth of the int_ext synchronizer (legal 2..4).
REQ-002 clk  input  1  global clock; all state SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  global reset, asynchronous, active-low.
REQ-004 int_timer  input  1  machine timer interrupt level from the timer block, synchronous to clk.
REQ-005 int_soft  input  1  machine software interrupt level (msip bit 0) from the timer block, synchronous to clk.
REQ-006 int_ext  input  1  external interrupt level, asynchronous to clk.
REQ-007 sel  input  1  block select.
REQ-008 addr  input  16  register address.
REQ-009 we  input  3  write control: we[2] = write strobe, we[1:0] = size (2'b10 = word).
REQ-010 wdata  input  32  write data.
REQ-011 rdata  output  32  read data.
REQ-012 global_ie  input  1  core mstatus.MIE.
REQ-013 irq_req  output  1  trap request to core.
REQ-014 irq_cause  output  4  exception code of the requested interrupt.
REQ-015 irq_ack  input  1  core accepts the trap.
REQ-016 mret  input  1  one-cycle pulse; handler return.

Function
REQ-017 Register map: 0x0000 mie (R/W, only bits 3, 7, 11 implemented, all other bits read 0); 0x0004 mip (read-only, bits 3, 7, 11).
REQ-018 mie SHALL be written on the rising edge when sel=1, we[2]=1, we[1:0]=2'b10 and addr=0x0000; all other writes SHALL be ignored.
REQ-019 rdata SHALL be combinational: the addressed register when sel=1, 32'h0 when sel=0 or the address is unmapped.
REQ-020 int_ext SHALL pass through SYNC_STAGES flops before reaching mip[11]; int_timer and int_soft SHALL each pass through one flop into mip[7] and mip[3].
REQ-021 mip bits SHALL be level-following (not latched); clearing the source clears the bit on the next update.
REQ-022 pending = mip & mie; an interrupt is eligible when pending != 0 and global_ie = 1.
REQ-023 Priority SHALL be 11 > 3 > 7; irq_cause SHALL carry 4'd11, 4'd3 or 4'd7.
REQ-024 The FSM SHALL have states IDLE, REQ and SERVICE.
REQ-025 IDLE -> REQ on the edge where the interrupt is eligible; in that edge irq_cause SHALL latch the highest-priority pending code. irq_req SHALL be 1 only in REQ.
REQ-026 In REQ, irq_req and irq_cause SHALL stay frozen until irq_ack=1, even if the source or global_ie drops. REQ -> SERVICE on the edge with irq_ack=1.
REQ-027 In SERVICE, no new request SHALL be made. SERVICE -> IDLE on the edge with mret=1.
REQ-028 irq_ack outside REQ and mret outside SERVICE SHALL be ignored.
REQ-029 After SERVICE -> IDLE with an interrupt still eligible, REQ SHALL be re-entered on the next edge (one IDLE cycle minimum).
REQ-030 A mie write that coincides with the IDLE evaluation edge SHALL take effect from the following edge.

Reset
REQ-031 rst_n=0 SHALL immediately force: FSM to IDLE, irq_req=0, irq_cause=4'd0, mie=0, mip=0, synchronizer flops=0. This applies mid-REQ and mid-SERVICE.
REQ-032 After rst_n deasserts, the first request SHALL NOT be made before the second rising edge.

Verification
REQ-033 Reset, then read 0x0000 and 0x0004 with sel=1 -> both 32'h0; with sel=0 -> rdata=32'h0.
REQ-034 Write 32'hFFFF_FFFF to 0x0000 -> read back 32'h0000_0888; write to 0x0004 -> mip unchanged.
REQ-035 mie=0x888, global_ie=1, int_timer=1 -> irq_req=1 and irq_cause=7 two edges later; hold irq_ack low and drop int_timer -> request held; pulse irq_ack -> irq_req=0 next edge.
REQ-036 Raise int_timer, int_soft and int_ext together with all enabled -> irq_cause=11; after ack and mret with int_ext low -> next request cause=3.
REQ-037 global_ie=0 with pending=0x080 -> no request; set global_ie=1 -> irq_req next edge.
REQ-038 Assert rst_n=0 during SERVICE -> irq_req=0 and mie=0 without waiting for a clock edge; mret afterwards has no effect.
